// File: rtl/sm_skid_pkg.sv
// sm_skid_pkg: state type and occupancy encodings shared by the skid register slice.
package sm_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } sm_skid_state_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

endpackage

// File: rtl/sm_en_areset_reg.sv
// sm_en_areset_reg: enable register with asynchronous active-high reset to p_reset_value.
//   clk, reset : clock and async reset
//   en         : load d into q on the posedge when high
//   d, q       : p_nbits data in / registered data out
module sm_en_areset_reg
    import sm_skid_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= p_reset_value;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/sm_skid_reg.sv
// sm_skid_reg: two-entry elastic pipeline register; in_rdy comes only from state flops.
//   clk, reset        : clock and async active-high reset
//   in_val/in_rdy/in_msg    : upstream handshake and message
//   out_val/out_rdy/out_msg : downstream handshake and head message
//   count             : occupancy 0..2
module sm_skid_reg
    import sm_skid_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic [1:0]         count
);

    logic [1:0]         r_state;
    logic [p_nbits-1:0] r_main;
    logic [p_nbits-1:0] r_skid;
    sm_skid_state_t     w_state;
    sm_skid_state_t     w_state_d;
    logic               w_main_en;
    logic               w_skid_en;
    logic [p_nbits-1:0] w_main_d;

    assign w_state = sm_skid_state_t'(r_state);

    // The skid slot is only written when a second message arrives while the head stalls.
    always_comb begin
        w_state_d = w_state;
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
        w_main_d  = in_msg;
        case (w_state)
            EMPTY: begin
                if (in_val) begin
                    w_state_d = ONE;
                    w_main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_val && !out_rdy) begin
                    w_state_d = TWO;
                    w_skid_en = 1'b1;
                end else if (in_val)
                    w_main_en = 1'b1;
                else if (out_rdy)
                    w_state_d = EMPTY;
            end
            TWO: begin
                if (out_rdy) begin
                    w_state_d = ONE;
                    w_main_en = 1'b1;
                    w_main_d  = r_skid;
                end
            end
            default: w_state_d = EMPTY;
        endcase
    end

    sm_en_areset_reg #(.p_nbits(p_nbits), .p_reset_value(p_reset_value)) u_main (
        .clk(clk), .reset(reset), .en(w_main_en), .d(w_main_d), .q(r_main)
    );

    sm_en_areset_reg #(.p_nbits(p_nbits), .p_reset_value(p_reset_value)) u_skid (
        .clk(clk), .reset(reset), .en(w_skid_en), .d(in_msg), .q(r_skid)
    );

    sm_en_areset_reg #(.p_nbits(2), .p_reset_value(2'(EMPTY))) u_state (
        .clk(clk), .reset(reset), .en(1'b1), .d(w_state_d), .q(r_state)
    );

    assign out_msg = r_main;
    assign out_val = (w_state != EMPTY);
    assign in_rdy  = (w_state != TWO);
    assign count   = (w_state == TWO) ? CNT_TWO : (w_state == ONE) ? CNT_ONE : CNT_EMPTY;

`ifndef SYNTHESIS
    logic               r_hold;
    logic [p_nbits-1:0] r_held_msg;

    // A stalled head must stay put until it is taken downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold     <= 1'b0;
            r_held_msg <= p_reset_value;
        end else begin
            assert (!$isunknown(in_val)) else $error("in_val is X");
            assert (!$isunknown(out_rdy)) else $error("out_rdy is X");
            if (r_hold)
                assert (out_msg == r_held_msg) else $error("out_msg changed while stalled");
            r_hold     <= out_val && !out_rdy;
            r_held_msg <= out_msg;
        end
    end
`endif

endmodule

// File: tb/tb_sm_skid_reg.sv
// tb_sm_skid_reg: directed and random checks of sm_skid_reg against a FIFO model.
module tb_sm_skid_reg;

    localparam logic [31:0] RV = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] in_msg = '0;
    logic        out_val;
    logic        out_rdy = 1'b0;
    logic [31:0] out_msg;
    logic [1:0]  count;

    int tests = 0;
    int fails = 0;
    logic [31:0] q[$];

    sm_skid_reg #(.p_nbits(32), .p_reset_value(RV)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of depth 2; accepts while not full, delivers while not empty.
    always @(posedge clk or posedge reset) begin
        if (reset)
            q.delete();
        else begin
            int n;
            bit acc;
            n = q.size();
            acc = in_val && (n < 2);
            if (out_rdy && n > 0)
                void'(q.pop_front());
            if (acc)
                q.push_back(in_msg);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model out_val", 32'(out_val), 32'(q.size() != 0));
            check("model in_rdy", 32'(in_rdy), 32'(q.size() < 2));
            check("model count", 32'(count), 32'(q.size()));
            if (q.size() != 0)
                check("model out_msg", out_msg, q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        in_val = 1'b1; in_msg = 32'h33; out_rdy = 1'b0;
        step();
        check("pre-reset out_msg", out_msg, 32'h33);
        in_val = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async out_val", 32'(out_val), 32'd0);
        check("async in_rdy", 32'(in_rdy), 32'd1);
        check("async count", 32'(count), 32'd0);
        check("async out_msg", out_msg, RV);
        #2 reset = 1'b0;
        out_rdy = 1'b1; in_val = 1'b1; in_msg = 32'h1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("stream out_msg", out_msg, 32'(i));
            check("stream count", 32'(count), 32'd1);
            in_msg = 32'(i + 1);
            if (i == 8) in_val = 1'b0;
        end
        step();
        check("stream end out_val", 32'(out_val), 32'd0);
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'hA;
        step();
        in_msg = 32'hB;
        step();
        check("stall count", 32'(count), 32'd2);
        check("stall in_rdy", 32'(in_rdy), 32'd0);
        check("stall out_msg", out_msg, 32'hA);
        in_val = 1'b0; out_rdy = 1'b1;
        step();
        check("unstall out_msg", out_msg, 32'hB);
        check("unstall in_rdy", 32'(in_rdy), 32'd1);
        step();
        check("unstall drained", 32'(out_val), 32'd0);
        in_val = 1'b1; in_msg = 32'h55; out_rdy = 1'b0;
        step();
        check("drain hold", out_msg, 32'h55);
        in_val = 1'b0; out_rdy = 1'b1;
        step();
        check("drain out_val", 32'(out_val), 32'd0);
        check("drain count", 32'(count), 32'd0);
        in_val = 1'b1; in_msg = 32'h66; out_rdy = 1'b0;
        step();
        in_msg = 32'h67;
        step();
        check("pre-reset TWO", 32'(count), 32'd2);
        in_val = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midop count", 32'(count), 32'd0);
        check("midop out_val", 32'(out_val), 32'd0);
        #2 reset = 1'b0;
        in_val = 1'b1; in_msg = 32'h77;
        step();
        check("post-reset msg", out_msg, 32'h77);
        check("post-reset count", 32'(count), 32'd1);
        in_val = 1'b0; out_rdy = 1'b1;
        step();
        check("post-reset empty", 32'(out_val), 32'd0);
        for (int i = 0; i < 10000; i++) begin
            in_val = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            in_msg = $urandom;
            step();
        end
        in_val = 1'b0; out_rdy = 1'b1;
        step();
        step();
        check("final empty", 32'(count), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
